// File: rtl/spi_rw_master_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | spi_rw_master_if : command handshake and SPI pin bundle              |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface spi_rw_master_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8,
  parameter int NUM_SS = 4,
  parameter int SS_W   = 2
);
  logic              start;
  logic              rw;
  logic [SS_W-1:0]   ss_sel;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              busy;
  logic              done;
  logic              err;
  logic              sck;
  logic              mosi;
  logic              miso;
  logic [NUM_SS-1:0] ss_n;

  modport master (
    input  start, rw, ss_sel, addr, wdata, miso,
    output rdata, busy, done, err, sck, mosi, ss_n
  );

  modport slave (
    output start, rw, ss_sel, addr, wdata, miso,
    input  rdata, busy, done, err, sck, mosi, ss_n
  );
endinterface
`default_nettype wire

// File: rtl/spi_rw_master.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | spi_rw_master : mode-0 SPI master, one {rw,addr,data} frame per start |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module spi_rw_master #(
  parameter int ADDR_W  = 7,
  parameter int DATA_W  = 8,
  parameter int NUM_SS  = 4,
  parameter int SS_W    = 2,
  parameter int CLK_DIV = 2
) (
  input  wire logic       sclk,
  input  wire logic       rst,
  spi_rw_master_if.master bus
);
  localparam int c_FRAME_W = 1 + ADDR_W + DATA_W;
  localparam int c_DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int c_CNT_W   = $clog2(c_FRAME_W + 1);

  localparam logic [c_DIV_W-1:0] c_DIV_LAST   = c_DIV_W'(CLK_DIV - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST   = c_CNT_W'(c_FRAME_W - 1);
  localparam logic [c_CNT_W-1:0] c_DATA_FIRST = c_CNT_W'(1 + ADDR_W);
  localparam logic [NUM_SS-1:0]  c_SS_ONE     = NUM_SS'(1);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_SHIFT = 2'd1;
  localparam logic [1:0] c_HOLD  = 2'd2;
  localparam logic [1:0] c_DONE  = 2'd3;

  logic [1:0]           r_state;
  logic [1:0]           w_next;
  logic [c_DIV_W-1:0]   r_div;
  logic [c_CNT_W-1:0]   r_cnt;
  logic [c_FRAME_W-1:0] r_sr;
  logic [DATA_W-1:0]    r_rx;
  logic [DATA_W-1:0]    r_rdata;
  logic [NUM_SS-1:0]    r_ss_n;
  logic                 r_rw;
  logic                 r_sck;
  logic                 r_mosi;
  logic                 r_done;
  logic                 r_err;

  logic [SS_W-1:0]      w_sel;
  logic [DATA_W-1:0]    w_wdata_eff;
  logic                 w_valid_sel;
  logic                 w_accept;
  logic                 w_reject;
  logic                 w_tick;
  logic                 w_rise;
  logic                 w_fall;
  logic                 w_last_fall;
  logic                 w_hold_end;
  logic                 w_busy;

  always_ff @(posedge sclk) begin
    if (rst) r_state <= c_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_IDLE: begin
        if (w_accept)      w_next = c_SHIFT;
        else if (w_reject) w_next = c_DONE;
      end
      c_SHIFT: if (w_last_fall) w_next = c_HOLD;
      c_HOLD:  if (w_hold_end)  w_next = c_IDLE;
      c_DONE:  w_next = c_IDLE;
      default: w_next = c_IDLE;
    endcase
  end

  always_comb begin
    w_sel       = bus.ss_sel;
    w_valid_sel = (int'(w_sel) < NUM_SS);
    // Read frames shift zeros out during the data field.
    w_wdata_eff = bus.rw ? '0 : bus.wdata;
    w_accept    = (r_state == c_IDLE) && bus.start && w_valid_sel;
    w_reject    = (r_state == c_IDLE) && bus.start && !w_valid_sel;
    w_tick      = (r_div == c_DIV_LAST);
    w_rise      = (r_state == c_SHIFT) && w_tick && !r_sck;
    w_fall      = (r_state == c_SHIFT) && w_tick && r_sck;
    w_last_fall = w_fall && (r_cnt == c_CNT_LAST);
    w_hold_end  = (r_state == c_HOLD) && w_tick;
    w_busy      = (r_state == c_SHIFT) || (r_state == c_HOLD);
  end

  always_ff @(posedge sclk) begin
    if (rst) begin
      r_div   <= '0;
      r_cnt   <= '0;
      r_sr    <= '0;
      r_rx    <= '0;
      r_rdata <= '0;
      r_ss_n  <= '1;
      r_rw    <= 1'b0;
      r_sck   <= 1'b0;
      r_mosi  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= w_hold_end || (r_state == c_DONE);
      r_err  <= (r_state == c_DONE);

      // One divider serves both the sck half-periods and the select hold time.
      if (w_busy) r_div <= w_tick ? '0 : r_div + 1'b1;
      else        r_div <= '0;

      if (w_accept) begin
        r_sr   <= {bus.rw, bus.addr, w_wdata_eff};
        r_rw   <= bus.rw;
        r_ss_n <= ~(c_SS_ONE << w_sel);
        r_mosi <= bus.rw;
        r_sck  <= 1'b0;
        r_cnt  <= '0;
        r_rx   <= '0;
      end

      if (w_rise) begin
        r_sck <= 1'b1;
        if (r_rw && (r_cnt >= c_DATA_FIRST)) r_rx <= (r_rx << 1) | DATA_W'(bus.miso);
      end

      if (w_fall) begin
        r_sck  <= 1'b0;
        r_sr   <= r_sr << 1;
        r_mosi <= w_last_fall ? 1'b0 : r_sr[c_FRAME_W-2];
        r_cnt  <= r_cnt + 1'b1;
      end

      if (w_hold_end) begin
        r_ss_n <= '1;
        if (r_rw) r_rdata <= r_rx;
      end
    end
  end

  assign bus.rdata = r_rdata;
  assign bus.busy  = w_busy;
  assign bus.done  = r_done;
  assign bus.err   = r_err;
  assign bus.sck   = r_sck;
  assign bus.mosi  = r_mosi;
  assign bus.ss_n  = r_ss_n;
endmodule
`default_nettype wire

// File: tb/tb_spi_rw_master.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_spi_rw_master : scoreboard bench over four parameter variants     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_spi_rw_master;
  localparam int AW = 7;
  localparam int DW = 8;
  localparam int FW = 1 + AW + DW;

  typedef struct {
    int         e0;
    int         lat;
    int         div;
    int         tog;
    bit         err;
    logic [7:0] rdata;
    logic [3:0] ss_n;
  } exp_t;

  logic       sclk = 1'b0;
  logic       rst;
  logic       start;
  logic       rw;
  logic       miso = 1'b0;
  logic [1:0] ss_sel;
  logic [6:0] addr;
  logic [7:0] wdata;
  logic [7:0] slave_data;
  logic [7:0] last_rd [4];
  int         cur;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;

  exp_t expq[$];
  logic bitq[$];

  always #5 sclk = ~sclk;
  always @(posedge sclk) cyc <= cyc + 1;

  spi_rw_master_if #(.ADDR_W(7), .DATA_W(8), .NUM_SS(4), .SS_W(2)) if0 ();
  spi_rw_master_if #(.ADDR_W(7), .DATA_W(8), .NUM_SS(4), .SS_W(2)) if1 ();
  spi_rw_master_if #(.ADDR_W(7), .DATA_W(8), .NUM_SS(4), .SS_W(2)) if2 ();
  spi_rw_master_if #(.ADDR_W(7), .DATA_W(8), .NUM_SS(3), .SS_W(2)) if3 ();

  spi_rw_master #(.ADDR_W(7), .DATA_W(8), .NUM_SS(4), .SS_W(2), .CLK_DIV(2))
    u_dut0 (.sclk(sclk), .rst(rst), .bus(if0));
  spi_rw_master #(.ADDR_W(7), .DATA_W(8), .NUM_SS(4), .SS_W(2), .CLK_DIV(1))
    u_dut1 (.sclk(sclk), .rst(rst), .bus(if1));
  spi_rw_master #(.ADDR_W(7), .DATA_W(8), .NUM_SS(4), .SS_W(2), .CLK_DIV(5))
    u_dut2 (.sclk(sclk), .rst(rst), .bus(if2));
  spi_rw_master #(.ADDR_W(7), .DATA_W(8), .NUM_SS(3), .SS_W(2), .CLK_DIV(2))
    u_dut3 (.sclk(sclk), .rst(rst), .bus(if3));

  // Only the selected instance sees start; data inputs are shared.
  assign if0.start = start && (cur == 0);
  assign if1.start = start && (cur == 1);
  assign if2.start = start && (cur == 2);
  assign if3.start = start && (cur == 3);
  assign if0.rw = rw;  assign if0.ss_sel = ss_sel;  assign if0.addr = addr;  assign if0.wdata = wdata;  assign if0.miso = miso;
  assign if1.rw = rw;  assign if1.ss_sel = ss_sel;  assign if1.addr = addr;  assign if1.wdata = wdata;  assign if1.miso = miso;
  assign if2.rw = rw;  assign if2.ss_sel = ss_sel;  assign if2.addr = addr;  assign if2.wdata = wdata;  assign if2.miso = miso;
  assign if3.rw = rw;  assign if3.ss_sel = ss_sel;  assign if3.addr = addr;  assign if3.wdata = wdata;  assign if3.miso = miso;

  logic       m_sck, m_mosi, m_busy, m_done, m_err;
  logic [3:0] m_ss_n;
  logic [7:0] m_rdata;

  always_comb begin
    m_sck = if0.sck;  m_mosi = if0.mosi;  m_busy = if0.busy;  m_done = if0.done;
    m_err = if0.err;  m_ss_n = if0.ss_n;  m_rdata = if0.rdata;
    if (cur == 1) begin
      m_sck = if1.sck;  m_mosi = if1.mosi;  m_busy = if1.busy;  m_done = if1.done;
      m_err = if1.err;  m_ss_n = if1.ss_n;  m_rdata = if1.rdata;
    end else if (cur == 2) begin
      m_sck = if2.sck;  m_mosi = if2.mosi;  m_busy = if2.busy;  m_done = if2.done;
      m_err = if2.err;  m_ss_n = if2.ss_n;  m_rdata = if2.rdata;
    end else if (cur == 3) begin
      m_sck = if3.sck;  m_mosi = if3.mosi;  m_busy = if3.busy;  m_done = if3.done;
      m_err = if3.err;  m_ss_n = {1'b1, if3.ss_n};  m_rdata = if3.rdata;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, want);
    end
  endtask

  task automatic push_exp(input int inst, input int e0, input bit r, input logic [1:0] sel,
                          input logic [6:0] a, input logic [7:0] d, input logic [7:0] sd);
    exp_t             e;
    logic [FW-1:0]    fr;
    int               nss;
    nss  = (inst == 3) ? 3 : 4;
    e.e0 = e0;
    e.div = (inst == 1) ? 1 : (inst == 2) ? 5 : 2;
    if (int'(sel) >= nss) begin
      e.lat = 1;  e.tog = 0;  e.err = 1'b1;  e.ss_n = 4'hF;
    end else begin
      e.lat  = (2 * FW + 1) * e.div;
      e.tog  = 2 * FW;
      e.err  = 1'b0;
      e.ss_n = 4'hF & ~(4'b0001 << sel);
      fr = {r, a, (r ? 8'h00 : d)};
      for (int i = FW - 1; i >= 0; i--) bitq.push_back(fr[i]);
      if (r) last_rd[inst] = sd;
    end
    e.rdata = last_rd[inst];
    expq.push_back(e);
  endtask

  task automatic send(input int inst, input bit r, input logic [1:0] sel,
                      input logic [6:0] a, input logic [7:0] d, input logic [7:0] sd);
    cur = inst;  rw = r;  ss_sel = sel;  addr = a;  wdata = d;  slave_data = sd;
    push_exp(inst, cyc + 1, r, sel, a, d, sd);
    start = 1'b1;
    @(negedge sclk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int maxc);
    int n    = 0;
    bit seen = 1'b0;
    while (!seen && n < maxc) begin
      @(negedge sclk);
      n++;
      if (m_done) seen = 1'b1;
    end
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    @(negedge sclk);
  endtask

  // Monitor and slave model: registered outputs are stable on the falling edge.
  int   tog_cnt = 0;
  int   rise_cnt = 0;
  bit   busy_seen = 1'b0;
  logic prev_sck = 1'b0;
  logic prev_done = 1'b0;

  always @(negedge sclk) begin
    exp_t e;
    logic b;
    if (rst) begin
      tog_cnt = 0;  rise_cnt = 0;  busy_seen = 1'b0;
      prev_sck = 1'b0;  prev_done = 1'b0;  miso = 1'b0;
    end else begin
      if (m_busy) busy_seen = 1'b1;
      if (m_sck !== prev_sck) begin
        tog_cnt++;
        if (expq.size() == 0) chk("sck_without_frame", 32'(expq.size()), 32'd1);
        else begin
          chk("sck_toggle_time", 32'(cyc - expq[0].e0), 32'(tog_cnt * expq[0].div));
          if (m_sck) begin
            rise_cnt++;
            b = (bitq.size() > 0) ? bitq.pop_front() : 1'bx;
            chk("mosi_bit", 32'(m_mosi), 32'(b));
            chk("ss_n_frame", 32'(m_ss_n), 32'(expq[0].ss_n));
          end
        end
      end
      if (expq.size() > 0 && rise_cnt >= 1 + AW && rise_cnt < FW)
        miso = slave_data[DW - 1 - (rise_cnt - 1 - AW)];
      else
        miso = 1'b0;
      if (m_done) begin
        chk("done_single_cycle", 32'(prev_done), 32'd0);
        if (expq.size() == 0) chk("done_without_frame", 32'(expq.size()), 32'd1);
        else begin
          e = expq.pop_front();
          chk("done_latency", 32'(cyc - e.e0), 32'(e.lat));
          chk("err", 32'(m_err), 32'(e.err));
          chk("rdata", 32'(m_rdata), 32'(e.rdata));
          chk("ss_n_released", 32'(m_ss_n), 32'hF);
          chk("sck_toggles", 32'(tog_cnt), 32'(e.tog));
          chk("busy_seen", 32'(busy_seen), 32'(!e.err));
        end
        tog_cnt = 0;  rise_cnt = 0;  busy_seen = 1'b0;
      end
      prev_sck  = m_sck;
      prev_done = m_done;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int dn;
    rst = 1'b1;  start = 1'b0;  rw = 1'b0;  ss_sel = '0;  addr = '0;  wdata = '0;
    cur = 0;  slave_data = '0;
    foreach (last_rd[i]) last_rd[i] = '0;
    repeat (3) @(negedge sclk);
    chk("rst_ss_n", 32'(m_ss_n), 32'hF);
    chk("rst_sck", 32'(m_sck), 32'd0);
    chk("rst_mosi", 32'(m_mosi), 32'd0);
    chk("rst_busy", 32'(m_busy), 32'd0);
    chk("rst_done", 32'(m_done), 32'd0);
    chk("rst_err", 32'(m_err), 32'd0);
    chk("rst_rdata", 32'(m_rdata), 32'd0);
    rst = 1'b0;
    @(negedge sclk);

    send(0, 1'b0, 2'd1, 7'h05, 8'hA5, 8'h00);
    wait_done("wr_default", 200);
    send(0, 1'b1, 2'd0, 7'h03, 8'h00, 8'h3C);
    wait_done("rd_default", 200);

    // start held high across a whole frame: second accept on the edge after done
    cur = 0;  rw = 1'b0;  ss_sel = 2'd2;  addr = 7'h11;  wdata = 8'h5A;
    push_exp(0, cyc + 1, 1'b0, 2'd2, 7'h11, 8'h5A, 8'h00);
    push_exp(0, cyc + 1 + (2 * FW + 1) * 2 + 1, 1'b0, 2'd2, 7'h11, 8'h5A, 8'h00);
    start = 1'b1;
    n = 0;  dn = 0;
    while (dn < 2 && n < 400) begin
      @(negedge sclk);
      n++;
      if (m_done) dn++;
    end
    start = 1'b0;
    chk("held_start_frames", 32'(dn), 32'd2);
    repeat (2) @(negedge sclk);
    chk("held_no_third_accept", 32'(m_busy), 32'd0);

    // mid-frame start pulse and input changes must not disturb the frame
    send(0, 1'b0, 2'd3, 7'h7F, 8'h81, 8'h00);
    repeat (19) @(negedge sclk);
    rw = 1'b1;  ss_sel = 2'd0;  addr = 7'h00;  wdata = 8'hFF;  start = 1'b1;
    @(negedge sclk);
    start = 1'b0;
    chk("midframe_busy", 32'(m_busy), 32'd1);
    chk("midframe_ss_n", 32'(m_ss_n), 32'h7);
    wait_done("midframe", 200);
    repeat (3) @(negedge sclk);
    chk("midframe_no_extra", 32'(m_busy), 32'd0);

    // reset at E0+20 aborts the frame without a done pulse
    send(0, 1'b0, 2'd1, 7'h22, 8'h33, 8'h00);
    repeat (19) @(negedge sclk);
    rst = 1'b1;
    @(negedge sclk);
    chk("abort_ss_n", 32'(m_ss_n), 32'hF);
    chk("abort_sck", 32'(m_sck), 32'd0);
    chk("abort_busy", 32'(m_busy), 32'd0);
    chk("abort_done", 32'(m_done), 32'd0);
    expq.delete();
    bitq.delete();
    foreach (last_rd[i]) last_rd[i] = '0;
    @(negedge sclk);
    rst = 1'b0;
    n = 0;
    repeat (100) begin
      @(negedge sclk);
      if (m_done) n++;
    end
    chk("abort_no_done", 32'(n), 32'd0);
    send(0, 1'b0, 2'd0, 7'h01, 8'hC3, 8'h00);
    wait_done("wr_after_rst", 200);

    send(1, 1'b0, 2'd1, 7'h05, 8'hA5, 8'h00);
    wait_done("wr_div1", 100);
    send(2, 1'b0, 2'd2, 7'h5A, 8'h3C, 8'h00);
    wait_done("wr_div5", 400);

    send(3, 1'b0, 2'd3, 7'h12, 8'h34, 8'h00);
    chk("reject_ss_n", 32'(m_ss_n), 32'hF);
    chk("reject_sck", 32'(m_sck), 32'd0);
    chk("reject_busy", 32'(m_busy), 32'd0);
    wait_done("reject", 10);
    send(3, 1'b1, 2'd2, 7'h40, 8'h00, 8'hC5);
    wait_done("rd_nss3", 200);

    repeat (5) @(negedge sclk);
    chk("scoreboard_empty", 32'(expq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
